// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction fetch unit: issues single-outstanding instruction-memory reads, buffers
// returned words in a 2-entry FIFO toward decode, and handles redirects and misaligned targets.
module rv32i_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] redirect_base,
  input  logic [31:0] imm,
  input  logic [31:0] alu_out,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {StIdle, StFetch, StWait, StFault} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] req_addr_q;
  logic        outstanding_q;
  logic        drop_q;
  logic        fault_q;

  logic [31:0] instr_q [2];
  logic [31:0] addr_q  [2];
  logic        rd_ptr_q;
  logic        wr_ptr_q;
  logic [1:0]  count_q;
  logic [1:0]  count_d;

  logic [31:0] target;
  logic        redirect_take;
  logic        rsp;
  logic        issue;
  logic        push;
  logic        pop;

  // Redirect target selection; reserved encoding behaves like sequential flow.
  always_comb begin
    target = redirect_base + 32'd4;
    unique case (pc_sel)
      2'd1:    target = redirect_base + imm;
      2'd2:    target = {alu_out[31:1], 1'b0};
      default: target = redirect_base + 32'd4;
    endcase
  end

  // Handshake decode; a taken redirect overrides issue, push and pop in the same cycle.
  always_comb begin
    redirect_take = redirect_valid && (state_q != StFault);
    rsp           = imem_rvalid && outstanding_q;
    issue         = (state_q == StFetch) && !outstanding_q && !redirect_take &&
                    (({1'b0, count_q} + {2'b00, outstanding_q}) < 3'd2);
    push          = rsp && !drop_q && !redirect_take && (state_q == StWait);
    pop           = if_valid && if_ready && !redirect_take;
    count_d       = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Control FSM with PC, outstanding/drop tracking and sticky fault flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      req_addr_q    <= '0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      if (rsp) begin
        outstanding_q <= 1'b0;
        drop_q        <= 1'b0;
      end
      if (issue) begin
        outstanding_q <= 1'b1;
        req_addr_q    <= pc_q;
        pc_q          <= pc_q + 32'd4;
      end
      if (redirect_take) begin
        pc_q <= target;
        // A response still in flight belongs to the old path and must be discarded.
        if (outstanding_q && !rsp) drop_q <= 1'b1;
        if (target[1]) begin
          fault_q <= 1'b1;
          state_q <= StFault;
        end else begin
          state_q <= StFetch;
        end
      end else begin
        unique case (state_q)
          StIdle:  state_q <= StFetch;
          StFetch: if (issue) state_q <= StWait;
          StWait:  if (rsp) state_q <= StFetch;
          StFault: state_q <= StFault;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Two-entry instruction buffer; redirects flush it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q[0] <= '0;
      instr_q[1] <= '0;
      addr_q[0]  <= '0;
      addr_q[1]  <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= '0;
    end else if (redirect_take) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push) begin
        instr_q[wr_ptr_q] <= imem_rdata;
        addr_q[wr_ptr_q]  <= req_addr_q;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  // Output decode.
  always_comb begin
    imem_req    = issue;
    imem_addr   = pc_q;
    if_valid    = (count_q != 2'd0);
    if_instr    = instr_q[rd_ptr_q];
    if_pc       = addr_q[rd_ptr_q];
    fetch_fault = fault_q;
  end

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Directed bench for the fetch unit with a behavioural instruction memory of configurable latency.
module tb_rv32i_fetch_unit;

  localparam logic [31:0] RstPc = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [1:0]  pc_sel;
  logic [31:0] redirect_base;
  logic [31:0] imm;
  logic [31:0] alu_out;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_fault;

  rv32i_fetch_unit #(.RESET_PC(RstPc)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .pc_sel        (pc_sel),
    .redirect_base (redirect_base),
    .imm           (imm),
    .alu_out       (alu_out),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .fetch_fault   (fetch_fault)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned lat      = 1;
  int unsigned pend_cnt = 0;
  logic [31:0] pend_data;
  logic [7:0]  serial   = 8'd0;
  logic        v_at_neg;
  logic [31:0] pc_at_neg;

  logic [31:0] req_log   [$];
  logic [31:0] data_log  [$];
  logic [31:0] pop_pc    [$];
  logic [31:0] pop_instr [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
  endfunction

  // One clock: sample on the falling edge, then model memory response 1 time unit after rise.
  task automatic tick();
    logic [31:0] d;
    @(negedge clk);
    v_at_neg  = if_valid;
    pc_at_neg = if_pc;
    if (imem_req) begin
      d = {serial, imem_addr[23:0]};
      req_log.push_back(imem_addr);
      data_log.push_back(d);
      serial    = serial + 8'd1;
      pend_cnt  = lat;
      pend_data = d;
    end
    if (if_valid && if_ready) begin
      pop_pc.push_back(if_pc);
      pop_instr.push_back(if_instr);
    end
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    if (pend_cnt != 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = pend_data;
      end
    end
  endtask

  task automatic clear_logs();
    req_log.delete();
    data_log.delete();
    pop_pc.delete();
    pop_instr.delete();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply_reset();
    rst_n          = 1'b0;
    pend_cnt       = 0;
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic redirect(input logic [1:0] sel, input logic [31:0] base, input logic [31:0] im,
                          input logic [31:0] alu);
    redirect_valid = 1'b1;
    pc_sel         = sel;
    redirect_base  = base;
    imm            = im;
    alu_out        = alu;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic run_until_req(input int budget);
    int n0;
    int k;
    n0 = req_log.size();
    k  = 0;
    while (req_log.size() == n0 && k < budget) begin
      tick();
      k++;
    end
    check("req_within_budget", 32'(req_log.size() > n0), 32'd1);
  endtask

  initial begin
    int          first_v;
    logic [31:0] first_pc;
    int          errs;
    logic        have;
    logic [31:0] h_pc;
    logic [31:0] h_instr;

    rst_n          = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    pc_sel         = 2'd0;
    redirect_base  = '0;
    imm            = '0;
    alu_out        = '0;
    if_ready       = 1'b1;

    // Sequential fetch with 1-cycle memory and an always-ready decoder.
    lat = 1;
    apply_reset();
    first_v  = -1;
    first_pc = '0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (first_v < 0 && v_at_neg) begin
        first_v  = k - 1;
        first_pc = pc_at_neg;
      end
    end
    check("first_valid_edges", 32'(first_v), 32'd3);
    check("first_valid_pc", first_pc, 32'h0040_0000);
    check("seq_addr0", at(req_log, 0), 32'h0040_0000);
    check("seq_addr1", at(req_log, 1), 32'h0040_0004);
    check("seq_addr2", at(req_log, 2), 32'h0040_0008);
    check("seq_pop0", at(pop_pc, 0), 32'h0040_0000);
    check("seq_pop1", at(pop_pc, 1), 32'h0040_0004);
    check("seq_pop2", at(pop_pc, 2), 32'h0040_0008);
    check("seq_instr1", at(pop_instr, 1), at(data_log, 1));

    // Backpressure: buffer fills to two entries and the head holds steady.
    if_ready = 1'b0;
    apply_reset();
    errs = 0;
    have = 1'b0;
    h_pc = '0;
    h_instr = '0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (if_valid) begin
        if (have && (if_pc !== h_pc || if_instr !== h_instr)) errs++;
        have    = 1'b1;
        h_pc    = if_pc;
        h_instr = if_instr;
      end
    end
    check("bp_req_count", 32'(req_log.size()), 32'd2);
    check("bp_valid", 32'(if_valid), 32'd1);
    check("bp_head_pc", if_pc, 32'h0040_0000);
    check("bp_stable_errs", 32'(errs), 32'd0);
    if_ready = 1'b1;
    ticks(8);
    check("bp_pop0", at(pop_pc, 0), 32'h0040_0000);
    check("bp_pop1", at(pop_pc, 1), 32'h0040_0004);
    check("bp_pop2", at(pop_pc, 2), 32'h0040_0008);
    check("bp_pop0_instr", at(pop_instr, 0), at(data_log, 0));

    // Redirect while waiting on a slow response: the stale word must be dropped.
    lat = 3;
    apply_reset();
    run_until_req(10);
    redirect(2'd1, 32'h0040_0010, 32'hFFFF_FFF0, 32'h0);
    check("drop_valid_after_redirect", 32'(if_valid), 32'd0);
    ticks(14);
    check("drop_next_addr", at(req_log, 1), 32'h0040_0000);
    check("drop_pop_pc", at(pop_pc, 0), 32'h0040_0000);
    check("drop_pop_instr", at(pop_instr, 0), at(data_log, 1));

    // JALR-style redirect with bit0 set, coinciding with an in-flight response.
    lat = 1;
    apply_reset();
    ticks(6);
    clear_logs();
    redirect(2'd2, 32'h0, 32'h0, 32'h0040_0101);
    pop_pc.delete();
    pop_instr.delete();
    check("jalr_valid_after_redirect", 32'(if_valid), 32'd0);
    ticks(6);
    check("jalr_addr", at(req_log, 0), 32'h0040_0100);
    check("jalr_fault", 32'(fetch_fault), 32'd0);
    check("jalr_pop_pc", at(pop_pc, 0), 32'h0040_0100);

    // Reserved selector falls back to base+4.
    clear_logs();
    redirect(2'd3, 32'h0040_0200, 32'h0000_DEAD, 32'h0);
    pop_pc.delete();
    pop_instr.delete();
    ticks(6);
    check("rsvd_addr", at(req_log, 0), 32'h0040_0204);
    check("rsvd_pop_pc", at(pop_pc, 0), 32'h0040_0204);

    // Misaligned target: sticky fault, no further requests, redirects ignored.
    redirect(2'd2, 32'h0, 32'h0, 32'h0040_0102);
    check("fault_set", 32'(fetch_fault), 32'd1);
    check("fault_valid", 32'(if_valid), 32'd0);
    clear_logs();
    redirect(2'd1, 32'h0040_0000, 32'h0, 32'h0);
    ticks(6);
    check("fault_no_req", 32'(req_log.size()), 32'd0);
    check("fault_sticky", 32'(fetch_fault), 32'd1);
    check("fault_valid_hold", 32'(if_valid), 32'd0);
    apply_reset();
    check("fault_cleared", 32'(fetch_fault), 32'd0);
    run_until_req(10);
    check("fault_reset_addr", at(req_log, 0), RstPc);

    // Asynchronous reset during an outstanding access, then a late response.
    lat = 2;
    if_ready = 1'b0;
    apply_reset();
    ticks(5);
    check("rst_pre_valid", 32'(if_valid), 32'd1);
    rst_n       = 1'b0;
    pend_cnt    = 0;
    imem_rvalid = 1'b0;
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_instr", if_instr, 32'h0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    tick();
    rst_n = 1'b1;
    clear_logs();
    if_ready = 1'b1;
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBADC_0DE0;
    tick();
    check("late_rsp_ignored", 32'(if_valid), 32'd0);
    ticks(6);
    check("late_first_addr", at(req_log, 0), RstPc);
    check("late_pop_pc", at(pop_pc, 0), RstPc);
    check("late_pop_instr", at(pop_instr, 0), at(data_log, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
